// File: rtl/fp_mul_io_pkg.sv
// Shared types and constants for the FP_MUL byte-serial I/O controller.
package fp_mul_io_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned WORD_W      = 64;
  localparam int unsigned NUM_BYTES   = 8;
  localparam int unsigned FRAME_BYTES = 16;
  localparam int unsigned CNT_W       = $clog2(FRAME_BYTES) + 1;
  localparam int unsigned WDOG_CYCLES = 64;
  localparam int unsigned WDOG_W      = $clog2(WDOG_CYCLES) + 1;

  localparam logic [WORD_W-1:0] CANON_QNAN = 64'h7FF8_0000_0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GO,
    ST_WAIT,
    ST_SEND
  } state_e;

endpackage

// File: rtl/fp_mul_io_ser.sv
// Result serializer: loads a 64-bit word and shifts it out LSB byte first over 8 cycles.
module fp_mul_io_ser
  import fp_mul_io_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [BYTE_W-1:0] byte_o,
  output logic              ready_o,
  output logic              done_o
);

  localparam int unsigned BCNT_W = $clog2(NUM_BYTES);

  logic [WORD_W-1:0] sh_q, sh_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              active_q, active_d;
  logic              done_q, done_d;

  // Zero fill on shift leaves the low byte at 0 once the last byte has gone out.
  always_comb begin
    sh_d     = sh_q;
    bcnt_d   = bcnt_q;
    active_d = active_q;
    if (load_i) begin
      sh_d     = data_i;
      bcnt_d   = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      sh_d   = sh_q >> BYTE_W;
      bcnt_d = bcnt_q + BCNT_W'(1);
      if (bcnt_q == BCNT_W'(NUM_BYTES - 1)) active_d = 1'b0;
    end
    done_d = active_d && (bcnt_d == BCNT_W'(NUM_BYTES - 1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q     <= '0;
      bcnt_q   <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      sh_q     <= sh_d;
      bcnt_q   <= bcnt_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign byte_o  = sh_q[BYTE_W-1:0];
  assign ready_o = active_q;
  assign done_o  = done_q;

endmodule

// File: rtl/fp_mul_io_ctrl.sv
// Byte-serial pad controller for the FP_MUL core: 16-byte operand frame in, 8-byte product out.
// Optional core-response watchdog is built when FPIO_WDOG_EN is defined.
module fp_mul_io_ctrl
  import fp_mul_io_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic [BYTE_W-1:0] DATA_IN,
  output logic [BYTE_W-1:0] DATA_OUT,
  output logic              READY,
  output logic [WORD_W-1:0] op_a,
  output logic [WORD_W-1:0] op_b,
  output logic              start,
  input  logic              core_done,
  input  logic [WORD_W-1:0] core_z
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                armed_q, armed_d;
  logic                start_q, start_d;
  logic                byte_we;
  logic [2*WORD_W-1:0] frame_q;
  logic                ser_load, ser_done;
  logic [WORD_W-1:0]   ser_data;
  logic                wdog_hit;

`ifdef FPIO_WDOG_EN
  logic [WDOG_W-1:0] wdog_q;

  // Counts WAIT cycles; expiry substitutes a canonical qNaN for the missing result.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                  wdog_q <= '0;
    else if (state_q == ST_WAIT) wdog_q <= wdog_q + WDOG_W'(1);
    else                         wdog_q <= '0;
  end

  assign wdog_hit = (state_q == ST_WAIT) && (wdog_q == WDOG_W'(WDOG_CYCLES - 1));
`else
  assign wdog_hit = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ENABLE && armed_q) state_d = ST_LOAD;
      ST_LOAD: begin
        if (!ENABLE)                                 state_d = ST_IDLE;
        else if (cnt_q == CNT_W'(FRAME_BYTES - 1))   state_d = ST_GO;
      end
      ST_GO:   state_d = ST_WAIT;
      ST_WAIT: if (core_done || wdog_hit) state_d = ST_SEND;
      ST_SEND: if (ser_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Armed re-arms on any ENABLE=0 sample so a host holding ENABLE high cannot retrigger.
  always_comb begin
    cnt_d    = cnt_q;
    armed_d  = ENABLE ? armed_q : 1'b1;
    byte_we  = 1'b0;
    ser_load = 1'b0;
    ser_data = core_z;
    start_d  = (state_d == ST_GO);
    case (state_q)
      ST_IDLE: begin
        if (ENABLE && armed_q) begin
          byte_we = 1'b1;
          cnt_d   = CNT_W'(1);
          armed_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (ENABLE) begin
          byte_we = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      ST_GO:   cnt_d = '0;
      ST_WAIT: begin
        if (core_done) begin
          ser_load = 1'b1;
        end else if (wdog_hit) begin
          ser_load = 1'b1;
          ser_data = CANON_QNAN;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q   <= '0;
      armed_q <= 1'b1;
      start_q <= 1'b0;
      frame_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      start_q <= start_d;
      if (byte_we) frame_q[{cnt_q[3:0], 3'b000} +: BYTE_W] <= DATA_IN;
    end
  end

  fp_mul_io_ser u_ser (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .load_i  (ser_load),
    .data_i  (ser_data),
    .byte_o  (DATA_OUT),
    .ready_o (READY),
    .done_o  (ser_done)
  );

  assign op_a  = frame_q[WORD_W-1:0];
  assign op_b  = frame_q[2*WORD_W-1:WORD_W];
  assign start = start_q;

endmodule
